writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The block SHALL have parameter W, default 32, meaning datapath width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter AW, default 5, meaning register-address width.
REQ-003 The block SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 The block SHALL have port stallW  input  1  hold the MEM/WB register.
REQ-006 The block SHALL have port flushW  input  1  replace the captured instruction with a bubble.
REQ-007 The block SHALL have port ValidM  input  1  the MEM-stage instruction is real, not a bubble.
REQ-008 The block SHALL have port RegWriteM  input  1  the MEM-stage instruction writes rd.
REQ-009 The block SHALL have port ResultSrcM  input  3  result select.
REQ-010 The block SHALL have port Funct3M  input  3  load type.
REQ-011 The block SHALL have port RdM  input  AW  destination register.
REQ-012 The block SHALL have ports ALUResultM, ReadDataM, PCPlus4M and ImmExtM  input  W  result candidates.
REQ-013 The block SHALL have port ResultW  output  W  write-back data.
REQ-014 The block SHALL have port RdW  output  AW  registered destination.
REQ-015 The block SHALL have port RegWriteW  output  1  register-file write enable.
REQ-016 The block SHALL have port ValidW  output  1  the registered instruction is real.
REQ-017 The block SHALL have port InstretW  output  64  retired-instruction counter.

Function
REQ-018 On each clk edge with flushW=1, the block SHALL clear the valid and RegWrite register bits; flushW SHALL take priority over stallW.
REQ-019 On each clk edge with flushW=0 and stallW=1, every MEM/WB register SHALL hold its value.
REQ-020 On each clk edge with flushW=0 and stallW=0, all M-stage inputs SHALL be captured.
REQ-021 Capture latency SHALL be one cycle; ResultW SHALL be a combinational function of the registered fields only.
REQ-022 ResultSrc select SHALL be: 000 ALUResult, 001 extended load data, 010 PCPlus4, 011 ImmExt, 100-111 ALUResult.
REQ-023 RegWriteW SHALL equal registered RegWrite AND registered Valid AND (RdW != 0); writes to x0 are suppressed.
REQ-024 InstretW SHALL increment by 1 on each edge where ValidW=1, stallW=0 and flushW=0.
REQ-025 InstretW SHALL wrap from 2^64-1 to 0 with no flag.
REQ-026 When stallW and flushW are both 0 and ValidW=0, InstretW SHALL be unchanged.
REQ-027 RdW and the data registers MAY hold stale values while Valid=0; ResultW is don't-care when RegWriteW=0.

Reset
REQ-028 Asserting rst SHALL immediately clear all registers without waiting for clk: ValidW=0, RegWriteW=0, RdW=0, InstretW=0, and the data registers to 0, giving ResultW=0.
REQ-029 rst asserted mid-stall or mid-flush SHALL override both controls.
REQ-030 The first capture after rst deasserts SHALL occur on the first clk edge with rst=0.

Configuration
REQ-031 When macro WB_LOAD_EXT_EN is defined, load data SHALL be aligned using byte offset ALUResult[log2(W/8)-1:0] and then extended.
REQ-032 Under WB_LOAD_EXT_EN, Funct3 000 (LB) and 001 (LH) SHALL sign-extend; 100 (LBU) and 101 (LHU) SHALL zero-extend.
REQ-033 Under WB_LOAD_EXT_EN, Funct3 010 (LW) SHALL sign-extend when W=64 and pass through when W=32.
REQ-034 Under WB_LOAD_EXT_EN, Funct3 110 (LWU, W=64) SHALL zero-extend; 011 and 111 SHALL pass the full word.
REQ-035 Without WB_LOAD_EXT_EN, ReadData SHALL pass unmodified for every Funct3, and the offset and Funct3 SHALL be ignored.

Verification
REQ-036 The bench SHALL apply rst=1 asynchronously between clk edges while ValidW=1 and InstretW=5, and SHALL check that ValidW=0, RegWriteW=0 and InstretW=0 before the next edge.
REQ-037 The bench SHALL capture ResultSrcM=011 with ImmExtM=0x12345000, RdM=7 and RegWriteM=1, and SHALL check ResultW=0x12345000 and RegWriteW=1 one cycle later.
REQ-038 The bench SHALL capture RdM=0 with RegWriteM=1 and ValidM=1, and SHALL check RegWriteW=0 while InstretW still increments on the next non-stalled edge.
REQ-039 The bench SHALL hold stallW=1 for 3 cycles with new M inputs, and SHALL check that ResultW and RdW are unchanged and that InstretW does not advance; it SHALL then assert stallW and flushW together and check ValidW=0.
REQ-040 With WB_LOAD_EXT_EN defined, the bench SHALL apply ReadData=0x80FF7F01, ALUResult[1:0]=2, ResultSrc=001: Funct3=000 SHALL give 0xFFFFFFFF and Funct3=100 SHALL give 0x000000FF.
REQ-041 With WB_LOAD_EXT_EN undefined, the bench SHALL repeat REQ-040 and check ResultW=0x80FF7F01 for both cases.

Source files
------------

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, result select and retired-instruction counter.
// Optional macro WB_LOAD_EXT_EN enables load-data alignment and sign/zero extension.
module writeback_stage #(
    parameter int W  = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stallW,
    input  logic          flushW,
    input  logic          ValidM,
    input  logic          RegWriteM,
    input  logic [2:0]    ResultSrcM,
    input  logic [2:0]    Funct3M,
    input  logic [AW-1:0] RdM,
    input  logic [W-1:0]  ALUResultM,
    input  logic [W-1:0]  ReadDataM,
    input  logic [W-1:0]  PCPlus4M,
    input  logic [W-1:0]  ImmExtM,
    output logic [W-1:0]  ResultW,
    output logic [AW-1:0] RdW,
    output logic          RegWriteW,
    output logic          ValidW,
    output logic [63:0]   InstretW
);

    localparam int OW = $clog2(W / 8);

    logic          valid_q;
    logic          regwrite_q;
    logic [2:0]    src_q;
    logic [2:0]    funct3_q;
    logic [AW-1:0] rd_q;
    logic [W-1:0]  alu_q;
    logic [W-1:0]  rdata_q;
    logic [W-1:0]  pc4_q;
    logic [W-1:0]  imm_q;
    logic [63:0]   instret_q;
    logic [W-1:0]  load_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            src_q      <= '0;
            funct3_q   <= '0;
            rd_q       <= '0;
            alu_q      <= '0;
            rdata_q    <= '0;
            pc4_q      <= '0;
            imm_q      <= '0;
            instret_q  <= '0;
        end else begin
            // The instruction sitting in WB retires when it is allowed to move on.
            if (valid_q && !stallW && !flushW)
                instret_q <= instret_q + 64'd1;
            if (flushW) begin
                valid_q    <= 1'b0;
                regwrite_q <= 1'b0;
            end else if (!stallW) begin
                valid_q    <= ValidM;
                regwrite_q <= RegWriteM;
                src_q      <= ResultSrcM;
                funct3_q   <= Funct3M;
                rd_q       <= RdM;
                alu_q      <= ALUResultM;
                rdata_q    <= ReadDataM;
                pc4_q      <= PCPlus4M;
                imm_q      <= ImmExtM;
            end
        end
    end

`ifdef WB_LOAD_EXT_EN
    logic [W-1:0] aligned;

    always_comb begin
        aligned = rdata_q >> {alu_q[OW-1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_data = W'($signed(aligned[7:0]));
            3'b001:  load_data = W'($signed(aligned[15:0]));
            3'b010:  load_data = W'($signed(aligned[31:0]));  // identity when W=32
            3'b100:  load_data = W'(aligned[7:0]);
            3'b101:  load_data = W'(aligned[15:0]);
            3'b110:  load_data = W'(aligned[31:0]);
            default: load_data = aligned;
        endcase
    end
`else
    logic unused_ext;
    assign unused_ext = ^funct3_q;
    assign load_data  = rdata_q;
`endif

    always_comb begin
        case (src_q)
            3'b001:  ResultW = load_data;
            3'b010:  ResultW = pc4_q;
            3'b011:  ResultW = imm_q;
            default: ResultW = alu_q;
        endcase
    end

    assign RdW       = rd_q;
    assign ValidW    = valid_q;
    assign RegWriteW = regwrite_q && valid_q && (rd_q != '0);
    assign InstretW  = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: vector table with a scoreboard queue,
// plus hand-written stall/flush, load-extension and asynchronous-reset sequences.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallW = 1'b0, flushW = 1'b0;
    logic        ValidM = 1'b0, RegWriteM = 1'b0;
    logic [2:0]  ResultSrcM = '0, Funct3M = '0;
    logic [4:0]  RdM = '0;
    logic [31:0] ALUResultM = '0, ReadDataM = '0, PCPlus4M = '0, ImmExtM = '0;
    logic [31:0] ResultW;
    logic [4:0]  RdW;
    logic        RegWriteW, ValidW;
    logic [63:0] InstretW;

    writeback_stage #(.W(32), .AW(5)) dut (
        .clk(clk), .rst(rst), .stallW(stallW), .flushW(flushW),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .Funct3M(Funct3M), .RdM(RdM), .ALUResultM(ALUResultM),
        .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
        .ResultW(ResultW), .RdW(RdW), .RegWriteW(RegWriteW),
        .ValidW(ValidW), .InstretW(InstretW)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        we;
        logic [2:0]  src;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [31:0] exp_res;
        logic        exp_we;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        we;
        logic        valid;
        logic [4:0]  rd;
    } exp_t;

    vec_t  vecs[10];
    exp_t  sb[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    logic        m_valid = 1'b0;
    logic [63:0] m_inst  = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        ValidM = v.valid; RegWriteM = v.we; ResultSrcM = v.src; Funct3M = v.f3;
        RdM = v.rd; ALUResultM = v.alu; ReadDataM = v.rdata; PCPlus4M = v.pc4;
        ImmExtM = v.imm;
        e.res = v.exp_res; e.we = v.exp_we; e.valid = v.valid; e.rd = v.rd;
        sb.push_back(e);
    endtask

    // One clock edge; the model tracks retirement and valid before the edge.
    task automatic step(input logic st, input logic fl);
        stallW = st; flushW = fl;
        if (m_valid && !st && !fl) m_inst = m_inst + 64'd1;
        if (fl) m_valid = 1'b0;
        else if (!st) m_valid = ValidM;
        @(posedge clk);
        #1;
        chk("instret", InstretW, m_inst);
        chk("valid", {63'd0, ValidW}, {63'd0, m_valid});
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            chk({name, "_we"}, {63'd0, RegWriteW}, {63'd0, e.we});
            if (e.we) chk({name, "_res"}, {32'd0, ResultW}, {32'd0, e.res});
            if (e.valid) chk({name, "_rd"}, {59'd0, RdW}, {59'd0, e.rd});
        end
    endtask

    vec_t lv;
    logic [31:0] held_res;
    logic [4:0]  held_rd;
    logic [63:0] held_inst;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 3'b000, 3'b000, 5'd1,  32'h11111111, 32'hAAAA0000, 32'h104, 32'h5000, 32'h11111111, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 3'b001, 3'b010, 5'd2,  32'h00000100, 32'hDEADBEEF, 32'h108, 32'h6000, 32'hDEADBEEF, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 3'b010, 3'b000, 5'd3,  32'h22222222, 32'h0,        32'h10C, 32'h7000, 32'h0000010C, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 3'b011, 3'b000, 5'd7,  32'h33333333, 32'h0,        32'h110, 32'h12345000, 32'h12345000, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 3'b100, 3'b000, 5'd4,  32'hCAFEF00D, 32'h1,        32'h114, 32'h8000, 32'hCAFEF00D, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 3'b111, 3'b000, 5'd5,  32'h0BADBEEF, 32'h2,        32'h118, 32'h9000, 32'h0BADBEEF, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 3'b000, 3'b000, 5'd0,  32'h00000077, 32'h0,        32'h11C, 32'h0,    32'h00000077, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 3'b000, 3'b000, 5'd6,  32'h00000099, 32'h0,        32'h120, 32'h0,    32'h00000099, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 3'b000, 3'b000, 5'd8,  32'h000000AA, 32'h0,        32'h124, 32'h0,    32'h000000AA, 1'b0};
        vecs[9] = '{1'b1, 1'b1, 3'b010, 3'b000, 5'd31, 32'h000000BB, 32'h0,        32'hFFFFFFFC, 32'h0, 32'hFFFFFFFC, 1'b1};

        // Reset state while rst is held.
        #12;
        chk("rst_valid", {63'd0, ValidW}, 64'd0);
        chk("rst_we", {63'd0, RegWriteW}, 64'd0);
        chk("rst_rd", {59'd0, RdW}, 64'd0);
        chk("rst_instret", InstretW, 64'd0);
        chk("rst_result", {32'd0, ResultW}, 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            step(1'b0, 1'b0);
            pop_check($sformatf("vec%0d", i));
        end

        // Stall three cycles with new M inputs: WB contents and counter hold.
        held_res = ResultW; held_rd = RdW; held_inst = InstretW;
        chk("pre_stall_res", {32'd0, held_res}, 64'hFFFFFFFC);
        for (int k = 0; k < 3; k++) begin
            ValidM = 1'b1; RegWriteM = 1'b1; ResultSrcM = 3'b000; RdM = 5'(10 + k);
            ALUResultM = 32'h5A5A0000 + k;
            step(1'b1, 1'b0);
            chk("stall_res", {32'd0, ResultW}, {32'd0, held_res});
            chk("stall_rd", {59'd0, RdW}, {59'd0, held_rd});
            chk("stall_instret", InstretW, held_inst);
        end
        step(1'b1, 1'b1);
        chk("stallflush_valid", {63'd0, ValidW}, 64'd0);
        chk("stallflush_we", {63'd0, RegWriteW}, 64'd0);

        // Load-data extension on a half-word offset.
        lv = '{1'b1, 1'b1, 3'b001, 3'b000, 5'd9, 32'h00000002, 32'h80FF7F01, 32'h0, 32'h0,
`ifdef WB_LOAD_EXT_EN
               32'hFFFFFFFF,
`else
               32'h80FF7F01,
`endif
               1'b1};
        drive(lv);
        step(1'b0, 1'b0);
        pop_check("lb_off2");
        lv.f3 = 3'b100;
`ifdef WB_LOAD_EXT_EN
        lv.exp_res = 32'h000000FF;
`endif
        drive(lv);
        step(1'b0, 1'b0);
        pop_check("lbu_off2");

        // Asynchronous reset mid-cycle with ValidW=1, InstretW=5, during a stall.
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        m_valid = 1'b0; m_inst = '0;
        for (int k = 0; k < 6; k++) begin
            ValidM = 1'b1; RegWriteM = 1'b1; ResultSrcM = 3'b000; RdM = 5'(1 + k);
            ALUResultM = 32'h100 + k;
            step(1'b0, 1'b0);
        end
        chk("pre_rst_instret", InstretW, 64'd5);
        chk("pre_rst_valid", {63'd0, ValidW}, 64'd1);
        stallW = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_valid", {63'd0, ValidW}, 64'd0);
        chk("async_we", {63'd0, RegWriteW}, 64'd0);
        chk("async_instret", InstretW, 64'd0);
        chk("async_result", {32'd0, ResultW}, 64'd0);
        #1 rst = 1'b0;
        m_valid = 1'b0; m_inst = '0;
        lv = '{1'b1, 1'b1, 3'b011, 3'b000, 5'd12, 32'h0, 32'h0, 32'h0, 32'hABCDE000, 32'hABCDE000, 1'b1};
        drive(lv);
        step(1'b0, 1'b0);
        pop_check("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
